// File: rtl/max7219_if.sv
// Bus between the calculator front end and the MAX7219 serial driver.
//   master : drives the refresh request (latch) and the display content
//            (num, dp, dp_en, brightness); observes busy and the serial pins.
//   slave  : the driver; samples the request/content, drives busy, sck, cs, din.
interface max7219_if #(
    parameter int DIGIT_NUM = 8
);
    logic                     latch;
    logic [4*DIGIT_NUM-1:0]   num;
    logic [2:0]               dp;
    logic                     dp_en;
    logic [3:0]               brightness;
    logic                     busy;
    logic                     sck;
    logic                     cs;
    logic                     din;

    modport master (
        output latch, num, dp, dp_en, brightness,
        input  busy, sck, cs, din
    );

    modport slave (
        input  latch, num, dp, dp_en, brightness,
        output busy, sck, cs, din
    );
endinterface

// File: rtl/max7219_driver.sv
// Serial driver for a MAX7219 8-digit 7-segment controller (Code-B decode).
// After reset it sends the init frames (shutdown off, decode, scan limit,
// test off) followed by a refresh; each latch request then sends one refresh
// (intensity frame plus one frame per digit).
// Ports:
//   clock  : system clock, all logic on the rising edge
//   reset  : synchronous, active-low
//   bus    : max7219_if slave modport
//            latch/num/dp/dp_en/brightness in; busy/sck/cs/din out
// Frame = 16 bits {4'h0, addr, data}, MSB first; din changes on sck falling.
module max7219_driver #(
    parameter int DIGIT_NUM = 8,
    parameter int CLK_DIV   = 4
) (
    input  logic      clock,
    input  logic      reset,
    max7219_if.slave  bus
);
    localparam int          NUM_W      = 4 * DIGIT_NUM;
    localparam logic [3:0]  LAST_IDX   = 4'(4 + DIGIT_NUM);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [7:0]  SCAN_LIMIT = 8'(DIGIT_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         bit_q, bit_d;
    logic [15:0]        div_q, div_d;
    logic               phase_q, phase_d;
    logic [15:0]        word_q, word_d;
    logic               init_q, init_d;
    logic               pending_q, pending_d;
    logic [NUM_W-1:0]   sh_num_q, sh_num_d;
    logic [2:0]         sh_dp_q, sh_dp_d;
    logic               sh_dp_en_q, sh_dp_en_d;
    logic [3:0]         sh_bright_q, sh_bright_d;
    logic [NUM_W-1:0]   wk_num_q, wk_num_d;
    logic [2:0]         wk_dp_q, wk_dp_d;
    logic               wk_dp_en_q, wk_dp_en_d;
    logic [3:0]         wk_bright_q, wk_bright_d;
    logic               sck_q, sck_d;
    logic               cs_q, cs_d;
    logic               din_q, din_d;
    logic               busy_q, busy_d;
    logic               load_s;
    logic               pending_clr_s;
    logic [15:0]        shift_word_s;

    // Build the 16-bit frame for a given sequence index from working data.
    function automatic logic [15:0] frame_word(
        input logic [3:0]       idx,
        input logic [NUM_W-1:0] n,
        input logic [2:0]       dp,
        input logic             dp_en,
        input logic [3:0]       bright
    );
        logic [3:0]       k;
        logic [NUM_W-1:0] shifted;
        logic [7:0]       data;
        k       = 4'h0;
        shifted = '0;
        data    = 8'h00;
        case (idx)
            4'd0:    frame_word = 16'h0C01;
            4'd1:    frame_word = 16'h09FF;
            4'd2:    frame_word = {8'h0B, SCAN_LIMIT};
            4'd3:    frame_word = 16'h0F00;
            4'd4:    frame_word = {8'h0A, 4'h0, bright};
            default: begin
                k = idx - 4'd5;
                if (32'(k) < DIGIT_NUM) begin
                    shifted    = n >> {k, 2'b00};
                    // dp positions beyond the driven digits never match a k
                    data       = {dp_en && (dp == k[2:0]), 3'b000, shifted[3:0]};
                    frame_word = {4'h0, k + 4'd1, data};
                end else begin
                    frame_word = 16'h0000;
                end
            end
        endcase
    endfunction

    // Next-state, shadow/working capture and registered-output computation.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        bit_d         = bit_q;
        div_d         = div_q;
        phase_d       = phase_q;
        init_d        = init_q;
        pending_d     = pending_q;
        sh_num_d      = sh_num_q;
        sh_dp_d       = sh_dp_q;
        sh_dp_en_d    = sh_dp_en_q;
        sh_bright_d   = sh_bright_q;
        wk_num_d      = wk_num_q;
        wk_dp_d       = wk_dp_q;
        wk_dp_en_d    = wk_dp_en_q;
        wk_bright_d   = wk_bright_q;
        word_d        = word_q;
        pending_clr_s = 1'b0;
        shift_word_s  = word_q;

        case (state_q)
            ST_IDLE: begin
                if (init_q) begin
                    state_d = ST_LOAD;
                    idx_d   = 4'd0;
                    init_d  = 1'b0;
                end else if (pending_q) begin
                    state_d       = ST_LOAD;
                    idx_d         = 4'd4;
                    pending_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // LOAD already counts as the first low clock of bit 15
                state_d = ST_SHIFT;
                if (CLK_DIV == 1) begin
                    phase_d = 1'b1;
                    div_d   = 16'd0;
                end else begin
                    phase_d = 1'b0;
                    div_d   = 16'd1;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = 16'd0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == 4'd0) begin
                        phase_d = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        // falling edge: the only place din may change
                        phase_d      = 1'b0;
                        bit_d        = bit_q - 4'd1;
                        shift_word_s = {word_q[14:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            ST_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = 16'd0;
                    state_d = ST_GAP;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (div_q == DIV_LAST) begin
                    div_d = 16'd0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                        idx_d   = idx_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        load_s = (state_d == ST_LOAD);

        // Snapshot the shadow at the intensity frame so a refresh never tears
        if (load_s && (idx_d == 4'd4)) begin
            wk_num_d    = sh_num_q;
            wk_dp_d     = sh_dp_q;
            wk_dp_en_d  = sh_dp_en_q;
            wk_bright_d = sh_bright_q;
        end else begin
            wk_num_d    = wk_num_q;
            wk_dp_d     = wk_dp_q;
            wk_dp_en_d  = wk_dp_en_q;
            wk_bright_d = wk_bright_q;
        end

        if (load_s) begin
            bit_d   = 4'd15;
            div_d   = 16'd0;
            phase_d = 1'b0;
            word_d  = frame_word(idx_d, wk_num_d, wk_dp_d, wk_dp_en_d, wk_bright_d);
        end else begin
            word_d = shift_word_s;
        end

        // A latch always wins over the pending clear, so no request is lost
        if (bus.latch) begin
            sh_num_d    = bus.num;
            sh_dp_d     = bus.dp;
            sh_dp_en_d  = bus.dp_en;
            sh_bright_d = bus.brightness;
            pending_d   = 1'b1;
        end else begin
            pending_d = pending_q && !pending_clr_s;
        end

        sck_d  = (state_d == ST_SHIFT) && phase_d;
        cs_d   = !((state_d == ST_LOAD) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
        din_d  = ((state_d == ST_LOAD) || (state_d == ST_SHIFT)) ? word_d[15] : 1'b0;
        busy_d = (state_d != ST_IDLE);
    end

    // State, data and output registers; reset aborts any frame in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            bit_q       <= 4'd0;
            div_q       <= 16'd0;
            phase_q     <= 1'b0;
            word_q      <= 16'h0000;
            init_q      <= 1'b1;
            pending_q   <= 1'b0;
            sh_num_q    <= {NUM_W{1'b1}};
            sh_dp_q     <= 3'd0;
            sh_dp_en_q  <= 1'b0;
            sh_bright_q <= 4'd0;
            wk_num_q    <= {NUM_W{1'b1}};
            wk_dp_q     <= 3'd0;
            wk_dp_en_q  <= 1'b0;
            wk_bright_q <= 4'd0;
            sck_q       <= 1'b0;
            cs_q        <= 1'b1;
            din_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            word_q      <= word_d;
            init_q      <= init_d;
            pending_q   <= pending_d;
            sh_num_q    <= sh_num_d;
            sh_dp_q     <= sh_dp_d;
            sh_dp_en_q  <= sh_dp_en_d;
            sh_bright_q <= sh_bright_d;
            wk_num_q    <= wk_num_d;
            wk_dp_q     <= wk_dp_d;
            wk_dp_en_q  <= wk_dp_en_d;
            wk_bright_q <= wk_bright_d;
            sck_q       <= sck_d;
            cs_q        <= cs_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.sck  = sck_q;
    assign bus.cs   = cs_q;
    assign bus.din  = din_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_max7219_driver.sv
// Directed bench for max7219_driver: a serial monitor rebuilds each frame
// from sck rising edges and compares it against a queue of expected words.
module tb_max7219_driver;
    localparam int DN = 8;
    localparam int CD = 4;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   mon_words;
    int   mon_rises;
    logic [15:0] sb[$];

    max7219_if #(.DIGIT_NUM(DN)) bus ();

    max7219_driver #(.DIGIT_NUM(DN), .CLK_DIV(CD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frames for one refresh, written from the register map.
    task automatic push_refresh(input logic [31:0] num, input logic [2:0] dp,
                                input logic dp_en, input logic [3:0] br);
        logic [31:0] n;
        n = num;
        sb.push_back({8'h0A, 4'h0, br});
        for (int k = 0; k < DN; k++) begin
            sb.push_back({8'(k + 1), (dp_en && (int'(dp) == k)), 3'b000, n[3:0]});
            n = n >> 4;
        end
    endtask

    task automatic push_init();
        sb.push_back(16'h0C01);
        sb.push_back(16'h09FF);
        sb.push_back(16'h0B07);
        sb.push_back(16'h0F00);
        push_refresh(32'hFFFFFFFF, 3'd0, 1'b0, 4'd0);
    endtask

    task automatic do_latch(input logic [31:0] num, input logic [2:0] dp,
                            input logic dp_en, input logic [3:0] br);
        @(posedge clock); #1;
        bus.num        = num;
        bus.dp         = dp;
        bus.dp_en      = dp_en;
        bus.brightness = br;
        bus.latch      = 1'b1;
        @(posedge clock); #1;
        bus.latch      = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input int limit, input string tag);
        int n;
        n = 0;
        while ((bus.busy !== level) && (n < limit)) begin
            @(negedge clock);
            n++;
        end
        check(tag, bus.busy, level);
    endtask

    // Serial monitor: frame capture plus timing rules on the pins.
    initial begin
        logic        prev_sck, prev_cs, prev_din, prev_reset;
        logic [15:0] bits;
        logic [15:0] exp_w;
        int          stable;
        prev_sck = 1'b0; prev_cs = 1'b1; prev_din = 1'b0; prev_reset = 1'b0;
        bits = 16'h0; stable = 0; mon_words = 0; mon_rises = 0;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                mon_rises = 0;
                bits      = 16'h0;
                stable    = 0;
            end else begin
                if (bus.din === prev_din) stable++;
                else stable = 1;
                if ((bus.sck === 1'b1) && (prev_sck === 1'b0)) begin
                    mon_rises++;
                    bits = {bits[14:0], bus.din};
                    check("din_setup", (stable >= CD + 1), 1'b1);
                    check("cs_low_at_rise", bus.cs, 1'b0);
                end
                if ((bus.cs === 1'b1) && (prev_cs === 1'b0) && (prev_reset === 1'b1)) begin
                    check("cs_rise_sck_low", {prev_sck, bus.sck}, 2'b00);
                    check("rises_per_frame", mon_rises, 16);
                    check("frame_expected", (sb.size() > 0), 1'b1);
                    if (sb.size() > 0) begin
                        exp_w = sb.pop_front();
                        check("frame_word", bits, exp_w);
                    end
                    mon_words++;
                    mon_rises = 0;
                end
            end
            prev_sck   = bus.sck;
            prev_cs    = bus.cs;
            prev_din   = bus.din;
            prev_reset = reset;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus.latch = 1'b0;
        bus.num   = 32'h0;
        bus.dp    = 3'd0;
        bus.dp_en = 1'b0;
        bus.brightness = 4'd0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_sck", bus.sck, 1'b0);
        check("rst_cs", bus.cs, 1'b1);
        check("rst_din", bus.din, 1'b0);
        check("rst_busy", bus.busy, 1'b1);

        // T1: init sequence and its length
        push_init();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        n = 0;
        while (n < 3000) begin
            @(negedge clock);
            if (bus.busy !== 1'b1) break;
            n++;
        end
        check("t1_busy_cycles", n, 13 * 136);
        repeat (5) @(negedge clock);
        check("t1_all_frames", sb.size(), 0);

        // T2: refresh with a decimal point on digit 2
        sb.push_back(16'h0A09); sb.push_back(16'h0105); sb.push_back(16'h0204);
        sb.push_back(16'h0383); sb.push_back(16'h0402); sb.push_back(16'h0501);
        sb.push_back(16'h060F); sb.push_back(16'h070F); sb.push_back(16'h080F);
        do_latch(32'hFFF12345, 3'd2, 1'b1, 4'd9);
        wait_busy(1'b1, 10, "t2_start");
        wait_busy(1'b0, 2000, "t2_end");
        repeat (5) @(negedge clock);
        check("t2_all_frames", sb.size(), 0);

        // T3: three latches during a refresh collapse into one more refresh
        push_refresh(32'h89ABCDEF, 3'd7, 1'b1, 4'd3);
        do_latch(32'h89ABCDEF, 3'd7, 1'b1, 4'd3);
        wait_busy(1'b1, 10, "t3_start");
        repeat (200) @(posedge clock);
        do_latch(32'h11111111, 3'd1, 1'b1, 4'd5);
        repeat (100) @(posedge clock);
        do_latch(32'h22222222, 3'd4, 1'b1, 4'd6);
        repeat (100) @(posedge clock);
        push_refresh(32'h00000000, 3'd0, 1'b0, 4'd12);
        do_latch(32'h00000000, 3'd0, 1'b0, 4'd12);
        check("t3_still_busy", bus.busy, 1'b1);
        wait_busy(1'b0, 2000, "t3_first_end");
        wait_busy(1'b1, 5, "t3_extra_start");
        wait_busy(1'b0, 2000, "t3_extra_end");
        repeat (300) @(negedge clock);
        check("t3_no_third", bus.busy, 1'b0);
        check("t3_all_frames", sb.size(), 0);

        // T6: dp position set but disabled
        push_refresh(32'h76543210, 3'd5, 1'b0, 4'd15);
        do_latch(32'h76543210, 3'd5, 1'b0, 4'd15);
        wait_busy(1'b1, 10, "t6_start");
        wait_busy(1'b0, 2000, "t6_end");
        repeat (5) @(negedge clock);
        check("t6_all_frames", sb.size(), 0);

        // T4: reset in the middle of frame 6, then full restart
        push_refresh(32'h13579BDF, 3'd3, 1'b1, 4'd7);
        base = mon_words;
        do_latch(32'h13579BDF, 3'd3, 1'b1, 4'd7);
        n = 0;
        while (!((mon_words == base + 2) && (mon_rises == 8)) && (n < 2000)) begin
            @(negedge clock);
            n++;
        end
        check("t4_reach_bit7", (n < 2000), 1'b1);
        repeat (CD) @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        @(posedge clock); #1;
        check("t4_cs_high", bus.cs, 1'b1);
        check("t4_sck_low", bus.sck, 1'b0);
        check("t4_busy_high", bus.busy, 1'b1);
        repeat (3) @(posedge clock);
        push_init();
        #1;
        reset = 1'b1;
        wait_busy(1'b0, 2500, "t4_restart_end");
        repeat (5) @(negedge clock);
        check("t4_all_frames", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
